line_encoder: RTL and testbench

Converts normalized light-grid instructions back into ASCII text lines ("turn on 0,0 through 999,999\n"), one byte per handshake. It is the inverse of the line decoder: it sits between an instruction source (stimulus generator or result replay) and the byte serializer feeding the host link. It gives a loopback path for decoder verification and lets the host read instructions back in human-readable form.

---
 rtl/line_encoder_if.sv | 30 +++
 rtl/line_encoder.sv | 175 +++++++++++++++++
 tb/tb_line_encoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/line_encoder_if.sv
// ============================================================================
// line_encoder_if : instruction-in / character-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface line_encoder_if #(
  parameter int INSTRUCTION_WIDTH   = 44,
  parameter int OUTBOUND_DATA_WIDTH = 8
);
  logic                           instr_valid;
  logic                           instr_ready;
  logic [INSTRUCTION_WIDTH-1:0]   instr_data;
  logic                           outbound_valid;
  logic                           outbound_ready;
  logic [OUTBOUND_DATA_WIDTH-1:0] outbound_data;
  logic                           end_of_file;

  modport master (
    output instr_valid, instr_data, outbound_ready,
    input  instr_ready, outbound_valid, outbound_data, end_of_file
  );

  modport slave (
    input  instr_valid, instr_data, outbound_ready,
    output instr_ready, outbound_valid, outbound_data, end_of_file
  );
endinterface

`default_nettype wire

// File: rtl/line_encoder.sv
// ============================================================================
// line_encoder : turns light-grid instruction words into ASCII text lines.
// Optional macro LINE_ENCODER_CRLF_EN selects a CR LF terminator.  Rev 1.0
// ============================================================================
`default_nettype none

module line_encoder #(
  parameter int INSTRUCTION_WIDTH   = 44,
  parameter int OUTBOUND_DATA_WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  line_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_OP_TEXT, S_START_ROW, S_COMMA_A, S_START_COL,
    S_THROUGH_TEXT, S_END_ROW, S_COMMA_B, S_END_COL, S_LINE_END
  } state_t;

  // Shorter strings are zero-padded at the top so char i sits at 8*(len-1-i).
  localparam logic [71:0] c_txt_off     = "turn off ";
  localparam logic [71:0] c_txt_on      = {8'h00, "turn on "};
  localparam logic [71:0] c_txt_toggle  = {16'h0000, "toggle "};
  localparam logic [71:0] c_txt_through = " through ";

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_eof, w_eof_nxt;
  logic        r_last;
  logic [1:0]  r_op;
  logic [9:0]  r_srow, r_scol, r_erow, r_ecol;

  logic        w_accept, w_xfer;
  logic [9:0]  w_num;
  logic [15:0] w_bcd;
  logic [2:0]  w_ndig;
  logic [1:0]  w_dpos;
  logic [3:0]  w_len, w_tpos;
  logic [71:0] w_txt;
  logic [OUTBOUND_DATA_WIDTH-1:0] w_char;

  function automatic logic [15:0] bin2bcd(input logic [9:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 9; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  assign w_accept           = bus.instr_valid & bus.instr_ready;
  assign w_xfer             = bus.outbound_valid & bus.outbound_ready;
  assign bus.instr_ready    = (r_state == S_IDLE);
  assign bus.outbound_valid = (r_state != S_IDLE);
  assign bus.outbound_data  = w_char;
  assign bus.end_of_file    = r_eof;

  always_comb begin
    w_num = '0;
    case (r_state)
      S_START_ROW: w_num = r_srow;
      S_START_COL: w_num = r_scol;
      S_END_ROW:   w_num = r_erow;
      S_END_COL:   w_num = r_ecol;
      default:     w_num = '0;
    endcase
  end

  assign w_bcd = bin2bcd(w_num);

  always_comb begin
    if (w_num >= 10'd1000)     w_ndig = 3'd4;
    else if (w_num >= 10'd100) w_ndig = 3'd3;
    else if (w_num >= 10'd10)  w_ndig = 3'd2;
    else                       w_ndig = 3'd1;
  end

  assign w_dpos = 2'(w_ndig - 3'd1 - {1'b0, r_idx[1:0]});
  assign w_tpos = w_len - 4'd1 - r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_eof_nxt   = 1'b0;
    w_len       = 4'd1;
    w_txt       = '0;
    w_char      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.instr_data[INSTRUCTION_WIDTH-2] && bus.instr_data[41:40] != 2'b11) begin
            w_state_nxt = S_OP_TEXT;
            w_idx_nxt   = '0;
          end else begin
            w_eof_nxt = bus.instr_data[INSTRUCTION_WIDTH-1];
          end
        end
      end
      S_OP_TEXT: begin
        case (r_op)
          2'b00:   begin w_txt = c_txt_off;    w_len = 4'd9; end
          2'b01:   begin w_txt = c_txt_on;     w_len = 4'd8; end
          default: begin w_txt = c_txt_toggle; w_len = 4'd7; end
        endcase
        w_char = w_txt[{w_tpos, 3'b000} +: 8];
      end
      S_THROUGH_TEXT: begin
        w_txt  = c_txt_through;
        w_len  = 4'd9;
        w_char = w_txt[{w_tpos, 3'b000} +: 8];
      end
      S_COMMA_A, S_COMMA_B: w_char = 8'h2C;
      S_LINE_END: begin
`ifdef LINE_ENCODER_CRLF_EN
        w_len  = 4'd2;
        w_char = (r_idx == 4'd0) ? 8'h0D : 8'h0A;
`else
        w_char = 8'h0A;
`endif
      end
      default: begin
        w_len  = {1'b0, w_ndig};
        w_char = {4'h3, w_bcd[{w_dpos, 2'b00} +: 4]};
      end
    endcase

    // Every non-idle state is one segment; the last char of a segment moves on.
    if (r_state != S_IDLE && w_xfer) begin
      if (r_idx == w_len - 4'd1) begin
        w_idx_nxt = '0;
        if (r_state == S_LINE_END) begin
          w_state_nxt = S_IDLE;
          w_eof_nxt   = r_last;
        end else begin
          w_state_nxt = state_t'(r_state + 4'd1);
        end
      end else begin
        w_idx_nxt = r_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_eof   <= 1'b0;
      r_last  <= 1'b0;
      r_op    <= '0;
      r_srow  <= '0;
      r_scol  <= '0;
      r_erow  <= '0;
      r_ecol  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_eof   <= w_eof_nxt;
      if (w_accept) begin
        r_last <= bus.instr_data[INSTRUCTION_WIDTH-1];
        r_op   <= bus.instr_data[41:40];
        r_srow <= bus.instr_data[39:30];
        r_scol <= bus.instr_data[29:20];
        r_erow <= bus.instr_data[19:10];
        r_ecol <= bus.instr_data[9:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_encoder.sv
// ============================================================================
// tb_line_encoder : directed timing checks plus randomized stall stream test.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_encoder;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  line_encoder_if #(.INSTRUCTION_WIDTH(44), .OUTBOUND_DATA_WIDTH(8)) bus ();

  line_encoder #(.INSTRUCTION_WIDTH(44), .OUTBOUND_DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] mk(input bit last, input bit lv, input bit [1:0] op,
                                     input int a, input int b, input int c, input int d);
    return {last, lv, op, 10'(a), 10'(b), 10'(c), 10'(d)};
  endfunction

  // Reference text for one instruction, built straight from the line format.
  function automatic string line_text(input logic [43:0] w);
    string opt, s;
    if (!w[42] || w[41:40] == 2'b11) return "";
    case (w[41:40])
      2'b00:   opt = "turn off ";
      2'b01:   opt = "turn on ";
      default: opt = "toggle ";
    endcase
    s = $sformatf("%s%0d,%0d through %0d,%0d", opt, w[39:30], w[29:20], w[19:10], w[9:0]);
`ifdef LINE_ENCODER_CRLF_EN
    s = $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
`else
    s = $sformatf("%s%c", s, 8'h0A);
`endif
    return s;
  endfunction

  // Monitor: collects transferred bytes and checks hold behaviour during stalls.
  bit       mon_en   = 0;
  bit       rnd_rdy  = 0;
  bit       prev_stall = 0;
  logic [7:0] prev_data = '0;
  byte      rx_q[$];
  int       eof_cnt  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.outbound_valid), 64'd1);
        check("stall_data", 64'(bus.outbound_data), 64'(prev_data));
      end
      if (bus.outbound_valid && bus.outbound_ready) rx_q.push_back(bus.outbound_data);
      prev_stall = bus.outbound_valid && !bus.outbound_ready;
      prev_data  = bus.outbound_data;
      if (bus.end_of_file) eof_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      bus.outbound_ready = 1'($urandom_range(0, 1));
    end
  end

  // Accept then check every byte on its exact cycle with ready held high.
  task automatic run_timed(input string tag, input logic [43:0] w);
    string s;
    s = line_text(w);
    @(posedge clk); #1;
    bus.outbound_ready = 1'b1;
    bus.instr_valid    = 1'b1;
    bus.instr_data     = w;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int k = 0; k < s.len(); k++) begin
      @(negedge clk);
      check({tag, "_valid"}, 64'(bus.outbound_valid), 64'd1);
      check({tag, "_byte"}, 64'(bus.outbound_data), 64'(s[k]));
    end
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(bus.instr_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(bus.outbound_valid), 64'd0);
    check({tag, "_eof"}, 64'(bus.end_of_file), 64'(w[43]));
  endtask

  task automatic send(input logic [43:0] w);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.instr_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  byte exp_q[$];
  int  exp_eof;

  initial begin
    logic [43:0] w;
    string s;
    reset              = 1'b0;
    bus.instr_valid    = 1'b0;
    bus.instr_data     = '0;
    bus.outbound_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.outbound_valid), 64'd0);
    check("rst_data", 64'(bus.outbound_data), 64'd0);
    check("rst_eof", 64'(bus.end_of_file), 64'd0);
    check("rst_ready", 64'(bus.instr_ready), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_timed("on_full", mk(1, 1, 2'b01, 0, 0, 999, 999));
    run_timed("off_1023", mk(0, 1, 2'b00, 1023, 5, 0, 10));
    run_timed("toggle", mk(1, 1, 2'b10, 499, 500, 501, 502));

    // Reserved opcode: nothing emitted, stays idle.
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(0, 1, 2'b11, 1, 2, 3, 4);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("rsv_ready", 64'(bus.instr_ready), 64'd1);
    check("rsv_valid", 64'(bus.outbound_valid), 64'd0);
    check("rsv_eof", 64'(bus.end_of_file), 64'd0);

    // Marker-only last: single end_of_file pulse.
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(1, 0, 2'b01, 7, 7, 7, 7);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("mark_eof", 64'(bus.end_of_file), 64'd1);
    check("mark_valid", 64'(bus.outbound_valid), 64'd0);
    check("mark_ready", 64'(bus.instr_ready), 64'd1);
    @(negedge clk);
    check("mark_eof_pulse", 64'(bus.end_of_file), 64'd0);

    // Reset in the middle of a line.
    @(posedge clk); #1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(1, 1, 2'b01, 123, 456, 789, 1000);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", 64'(bus.outbound_valid), 64'd0);
    check("abort_ready", 64'(bus.instr_ready), 64'd1);
    check("abort_data", 64'(bus.outbound_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_timed("after_abort", mk(0, 1, 2'b00, 8, 90, 100, 1019));

    // Random stream with random backpressure.
    exp_eof = 0;
    mon_en  = 1;
    rnd_rdy = 1;
    for (int n = 0; n < 100; n++) begin
      w = mk(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 2)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      s = line_text(w);
      for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
      if (w[43]) exp_eof++;
      send(w);
    end
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (rx_q.size() >= exp_q.size() && bus.instr_ready) break;
    end
    repeat (3) @(negedge clk);
    rnd_rdy = 0;
    mon_en  = 0;
    check("rnd_count", 64'(rx_q.size()), 64'(exp_q.size()));
    check("rnd_eof_count", 64'(eof_cnt), 64'(exp_eof));
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check("rnd_byte", 64'(rx_q[k]), 64'(exp_q[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
